// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback-port arbiter.
//   wb_sel_e    : writeback source select encoding used by the WB stage
//   arb_state_e : arbiter FSM state encoding
//   mdu_entry_t : one buffered MDU result (destination + data)
//   wb_mux()    : writeback source selection
package wb_arb_pkg;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_LOAD    = 2'b01,
    WB_PC4     = 2'b10,
    WB_PC4_ALT = 2'b11
  } wb_sel_e;

  typedef enum logic [0:0] {
    S_PIPE = 1'b0,
    S_MDU  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mdu_entry_t;

  function automatic logic [31:0] wb_mux(input wb_sel_e sel, input logic [31:0] alu,
                                         input logic [31:0] load, input logic [31:0] pc4);
    case (sel)
      WB_ALU:  return alu;
      WB_LOAD: return load;
      default: return pc4;
    endcase
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending FIFO for MDU results waiting for the register-file write port.
// Ports:
//   clk, rst_n     : clock, async active-low reset (empties the FIFO)
//   push, wdata    : enqueue one entry (caller guarantees not full, or popping)
//   pop            : dequeue head (caller guarantees not empty)
//   head           : current oldest entry
//   full, empty    : occupancy flags
//   count          : number of stored entries
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int PEND_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  mdu_entry_t                    wdata,
  input  logic                          pop,
  output mdu_entry_t                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(PEND_DEPTH):0]   count
);

  localparam int AW = $clog2(PEND_DEPTH);

  mdu_entry_t  mem [PEND_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage and buffered MDU results, stalls WB when the MDU must drain, and
// tracks outstanding MDU destinations for the hazard unit.
// Optional macro WB_STARVE_GUARD_EN: force an MDU grant after an entry has
// waited MAX_WAIT cycles behind pipeline writes.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   pipe_*                      : WB stage request and data sources
//   mdu_valid/rd/data, mdu_ready: MDU result handshake
//   issue_valid, issue_rd       : MDU op issue (sets busy bit)
//   rf_we, rf_rd, rf_wdata      : register-file write port (same-edge write)
//   wb_stall                    : hold the WB stage instruction
//   busy_vec                    : per-register outstanding MDU write
//
// state  | meaning
// S_PIPE | pipeline owns the port; MDU head written only when pipe is idle
// S_MDU  | MDU head owns the port; WB stage stalled
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int PEND_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [1:0]  pipe_wb_sel,
  input  logic [31:0] pipe_alu_data,
  input  logic [31:0] pipe_data_out,
  input  logic [31:0] pipe_pc_four,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        wb_stall,
  output logic [31:0] busy_vec
);

  localparam int AW = $clog2(PEND_DEPTH);

  arb_state_e  state;
  arb_state_e  state_nxt;
  mdu_entry_t  head;
  mdu_entry_t  push_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [AW:0] count_nxt;
  logic        full_nxt;
  logic        pipe_req;
  logic        mdu_req;
  logic        mdu_grant;
  logic        push;
  logic        force_mdu;
  logic [31:0] pipe_wdata;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  assign pipe_req   = pipe_valid & pipe_we & (pipe_rd != 5'd0);
  assign mdu_req    = ~fifo_empty;
  assign pipe_wdata = wb_mux(wb_sel_e'(pipe_wb_sel), pipe_alu_data, pipe_data_out, pipe_pc_four);

  // Granting the head always pops it; rd=0 heads are discarded without a write.
  assign mdu_grant  = mdu_req & ((state == S_MDU) | ~pipe_req);
  assign mdu_ready  = ~fifo_full | mdu_grant;
  assign push       = mdu_valid & mdu_ready;
  assign push_entry = '{rd: mdu_rd, data: mdu_data};

  // Write strobes are held off while reset is asserted.
  assign rf_we    = rst_n & (mdu_grant ? (head.rd != 5'd0) : ((state == S_PIPE) & pipe_req));
  assign rf_rd    = mdu_grant ? head.rd : pipe_rd;
  assign rf_wdata = mdu_grant ? head.data : pipe_wdata;
  assign wb_stall = rst_n & (state == S_MDU) & pipe_valid;

  wb_pend_fifo #(.PEND_DEPTH(PEND_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (mdu_grant),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(mdu_grant);
  assign full_nxt  = (count_nxt == (AW+1)'(PEND_DEPTH));

`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mdu_grant) begin
      wait_cnt <= '0;
    end else if (mdu_req && (wait_cnt != WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Enter S_MDU on the edge where the counter reaches MAX_WAIT; the grant
  // follows in the next cycle and the not-full exit returns to S_PIPE.
  assign force_mdu = mdu_req & ~mdu_grant & (wait_cnt == WW'(MAX_WAIT - 1));
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign force_mdu       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (state == S_PIPE) begin
      if ((pipe_req & fifo_full) | force_mdu) state_nxt = S_MDU;
    end else begin
      if (!full_nxt) state_nxt = S_PIPE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PIPE;
    else        state <= state_nxt;
  end

  // Set is applied after clear so a same-cycle issue to the same rd wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) set_vec[issue_rd] = 1'b1;
    if (mdu_grant)   clr_vec[head.rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= ((busy_vec & ~clr_vec) | set_vec) & ~32'd1;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [1:0]  pipe_wb_sel;
  logic [31:0] pipe_alu_data;
  logic [31:0] pipe_data_out;
  logic [31:0] pipe_pc_four;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [31:0] busy_vec;

  int tests_run;
  int tests_failed;

  mdu_entry_t  exp_q [$];
  mdu_entry_t  mon_e;
  logic [31:0] mux_exp [4];

  wb_port_arbiter #(.PEND_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_valid    (pipe_valid),
    .pipe_we       (pipe_we),
    .pipe_rd       (pipe_rd),
    .pipe_wb_sel   (pipe_wb_sel),
    .pipe_alu_data (pipe_alu_data),
    .pipe_data_out (pipe_data_out),
    .pipe_pc_four  (pipe_pc_four),
    .mdu_valid     (mdu_valid),
    .mdu_rd        (mdu_rd),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .wb_stall      (wb_stall),
    .busy_vec      (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    mdu_entry_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Every register-file write is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 32'(rf_rd), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_rd", 32'(rf_rd), 32'(mon_e.rd));
        chk("wr_data", rf_wdata, mon_e.data);
      end
    end
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    mux_exp[0] = 32'h11;
    mux_exp[1] = 32'h22;
    mux_exp[2] = 32'h1004;
    mux_exp[3] = 32'h1004;
    rst_n = 1'b0;
    pipe_valid = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wb_sel = 2'd0;
    pipe_alu_data = '0; pipe_data_out = '0; pipe_pc_four = '0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = '0;
    issue_valid = 1'b0; issue_rd = 5'd0;

    #12;
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_stall", 32'(wb_stall), 0);
    chk("reset_ready", 32'(mdu_ready), 1);
    chk("reset_busy", busy_vec, 0);
    rst_n = 1'b1;
    cyc();

    // writeback source mux
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd5;
    pipe_alu_data = 32'h11; pipe_data_out = 32'h22; pipe_pc_four = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      pipe_wb_sel = 2'(i);
      expect_wr(5'd5, mux_exp[i]);
      #1;
      chk("mux_we", 32'(rf_we), 1);
      cyc();
    end
    pipe_rd = 5'd0;
    #1;
    chk("mux_rd0_we", 32'(rf_we), 0);
    cyc();
    pipe_valid = 1'b0;

    // idle grant with busy tracking
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("idle_busy7_set", 32'(busy_vec[7]), 1);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEAD;
    #1;
    chk("idle_push_ready", 32'(mdu_ready), 1);
    chk("idle_push_no_wr", 32'(rf_we), 0);
    expect_wr(5'd7, 32'hDEAD);
    cyc();
    mdu_valid = 1'b0;
    #1;
    chk("idle_grant_we", 32'(rf_we), 1);
    chk("idle_grant_rd", 32'(rf_rd), 7);
    chk("idle_grant_data", rf_wdata, 32'hDEAD);
    chk("idle_busy7_held", 32'(busy_vec[7]), 1);
    cyc();
    chk("idle_busy7_clr", 32'(busy_vec[7]), 0);
    chk("idle_after_we", 32'(rf_we), 0);

    // full FIFO forces S_MDU
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wb_sel = 2'd0; pipe_alu_data = 32'hA0;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h100;
    expect_wr(5'd3, 32'hA0);
    #1;
    chk("full_ready_a", 32'(mdu_ready), 1);
    cyc();
    mdu_rd = 5'd13; mdu_data = 32'h200;
    expect_wr(5'd3, 32'hA0);
    #1;
    chk("full_ready_b", 32'(mdu_ready), 1);
    cyc();
    mdu_valid = 1'b0;
    expect_wr(5'd3, 32'hA0);
    #1;
    chk("full_not_ready", 32'(mdu_ready), 0);
    chk("full_no_stall", 32'(wb_stall), 0);
    cyc();
    expect_wr(5'd12, 32'h100);
    #1;
    chk("smdu_stall", 32'(wb_stall), 1);
    chk("smdu_ready", 32'(mdu_ready), 1);
    cyc();
    expect_wr(5'd3, 32'hA0);
    #1;
    chk("back_pipe_stall", 32'(wb_stall), 0);
    chk("back_pipe_rd", 32'(rf_rd), 3);
    cyc();
    pipe_valid = 1'b0;
    expect_wr(5'd13, 32'h200);
    #1;
    chk("drain_rd", 32'(rf_rd), 13);
    cyc();
    #1;
    chk("drain_empty_we", 32'(rf_we), 0);

    // issue/clear race on the same rd
    issue_valid = 1'b1; issue_rd = 5'd9;
    cyc();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    cyc();
    mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    expect_wr(5'd9, 32'h99);
    #1;
    chk("race_we", 32'(rf_we), 1);
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("race_busy9", 32'(busy_vec[9]), 1);
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h77;
    cyc();
    mdu_valid = 1'b0;
    expect_wr(5'd9, 32'h77);
    cyc();
    #1;
    chk("race_busy9_clr", 32'(busy_vec[9]), 0);

    // starvation behaviour with one entry and continuous pipe writes
    pipe_valid = 1'b1; pipe_rd = 5'd3;
    mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_data = 32'h55;
    expect_wr(5'd3, 32'hA0);
    cyc();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_wr(5'd3, 32'hA0);
      #1;
      chk("starve_wait_stall", 32'(wb_stall), 0);
      chk("starve_wait_rd", 32'(rf_rd), 3);
      cyc();
    end
`ifdef WB_STARVE_GUARD_EN
    expect_wr(5'd14, 32'h55);
    #1;
    chk("starve_force_stall", 32'(wb_stall), 1);
    chk("starve_force_rd", 32'(rf_rd), 14);
    cyc();
    expect_wr(5'd3, 32'hA0);
    #1;
    chk("starve_release_stall", 32'(wb_stall), 0);
    cyc();
`else
    for (int i = 0; i < 2; i++) begin
      expect_wr(5'd3, 32'hA0);
      #1;
      chk("starve_no_grant_rd", 32'(rf_rd), 3);
      chk("starve_no_grant_stall", 32'(wb_stall), 0);
      cyc();
    end
    pipe_valid = 1'b0;
    expect_wr(5'd14, 32'h55);
    #1;
    chk("starve_idle_rd", 32'(rf_rd), 14);
    cyc();
`endif
    pipe_valid = 1'b0;

    // reset mid-traffic with a full FIFO and busy bits 10/11
    pipe_valid = 1'b1; pipe_rd = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd10;
    expect_wr(5'd3, 32'hA0);
    cyc();
    issue_rd = 5'd11;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h1010;
    expect_wr(5'd3, 32'hA0);
    cyc();
    issue_valid = 1'b0;
    mdu_rd = 5'd11; mdu_data = 32'h1111;
    expect_wr(5'd3, 32'hA0);
    cyc();
    mdu_valid = 1'b0;
    #1;
    chk("pre_rst_busy", busy_vec, 32'h0000_0C00);
    chk("pre_rst_full", 32'(mdu_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_ready", 32'(mdu_ready), 1);
    chk("rst_stall", 32'(wb_stall), 0);
    pipe_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", 32'(mdu_ready), 1);
    chk("post_rst_we", 32'(rf_we), 0);
    chk("post_rst_busy", busy_vec, 0);
    cyc();
    chk("pending_wr", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
